// File: rtl/enc_arbiter.sv
// enc_arbiter: round-robin front end for a single encryption core.
// Accepts one {key, data} request at a time from NREQ requesters and drives
// the core inputs. After LAT core cycles it returns the encrypted byte and
// the requester ID over a valid/ready response channel.
// Optional feature macro: ENC_ARB_KEYCHK_EN (all-zero keys skip the core and
// are answered with rsp_err=1).
//
// state  | meaning
// IDLE   | arbitrate; accept winner on this edge
// WAIT   | core computing; cnt counting down
// RESP   | response presented; hold until rsp_ready

module enc_arbiter #(
  parameter int N    = 8,
  parameter int NREQ = 4,
  parameter int LAT  = 1,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_key,
  input  logic [NREQ*N-1:0] req_data,
  output logic [N-1:0]      core_key,
  output logic [N-1:0]      core_data,
  input  logic [N-1:0]      core_e_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [N-1:0]      rsp_data,
  output logic              rsp_err,
  output logic              busy
);

  localparam int CW = (LAT < 1) ? 1 : $clog2(LAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt;
  logic [IDW-1:0] last_grant;
  logic [IDW-1:0] winner;
  logic           found;
  logic [N-1:0]   win_key;
  logic [N-1:0]   win_data;
  logic           key_zero;
  logic           accept;

  // Round-robin search starting just after the last granted requester
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (int'(last_grant) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = IDW'(idx);
      end
    end
  end

  assign win_key  = req_key[int'(winner)*N +: N];
  assign win_data = req_data[int'(winner)*N +: N];
  assign accept   = (state == S_IDLE) && found;

`ifdef ENC_ARB_KEYCHK_EN
  assign key_zero = (win_key == '0);
`else
  assign key_zero = 1'b0;
`endif

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (found) state_nxt = key_zero ? S_RESP : S_WAIT;
      S_WAIT: if (cnt == '0) state_nxt = S_RESP;
      S_RESP: if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state; req_ready is also gated by reset_n so it
  // reads 0 while reset is held, even though state already sits in IDLE
  always_comb begin
    req_ready = '0;
    if (reset_n && accept) req_ready[winner] = 1'b1;
    busy      = (state != S_IDLE);
    rsp_valid = (state == S_RESP);
  end

  // Datapath: core inputs, countdown, response capture and grant pointer
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      core_key   <= '0;
      core_data  <= '0;
      cnt        <= '0;
      rsp_id     <= '0;
      rsp_data   <= '0;
      last_grant <= IDW'(NREQ - 1);
    end else begin
      case (state)
        S_IDLE: begin
          if (found) begin
            rsp_id     <= winner;
            last_grant <= winner;
            if (key_zero) begin
              rsp_data <= '0;
            end else begin
              core_key  <= win_key;
              core_data <= win_data;
              cnt       <= CW'(LAT);
            end
          end
        end
        S_WAIT: begin
          if (cnt != '0) cnt <= cnt - CW'(1);
          else           rsp_data <= core_e_data;
        end
        default: ;
      endcase
    end
  end

`ifdef ENC_ARB_KEYCHK_EN
  logic rsp_err_q;

  // Error flag is latched per accepted request and held through RESP
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)    rsp_err_q <= 1'b0;
    else if (accept) rsp_err_q <= key_zero;
  end

  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_enc_arbiter.sv
// Self-checking bench for enc_arbiter (N=8, NREQ=4, LAT=1).
// A one-cycle behavioural core model computes e = (key ^ data) + 8'h11.
// Expected responses are pushed to a queue by the stimulus; a monitor pops
// and compares on every response handshake.

module tb_enc_arbiter;

  logic        clock;
  logic        reset_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_key;
  logic [31:0] req_data;
  logic [7:0]  core_key;
  logic [7:0]  core_data;
  logic [7:0]  core_e_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_data;
  logic        rsp_err;
  logic        busy;

  logic [7:0] key_t [4];
  logic [7:0] dat_t [4];

  typedef struct {
    logic [1:0] id;
    logic [7:0] data;
    logic       err;
  } exp_t;

  exp_t exp_q[$];

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;

  enc_arbiter #(.N(8), .NREQ(4), .LAT(1)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_key     (req_key),
    .req_data    (req_data),
    .core_key    (core_key),
    .core_data   (core_data),
    .core_e_data (core_e_data),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
    .busy        (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Behavioural encryption core, one edge of latency
  always @(posedge clock) core_e_data <= (core_key ^ core_data) + 8'h11;

  always_comb begin
    req_key  = '0;
    req_data = '0;
    for (int i = 0; i < 4; i++) begin
      req_key[i*8 +: 8]  = key_t[i];
      req_data[i*8 +: 8] = dat_t[i];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push_exp(input logic [1:0] id, input logic [7:0] data, input logic err);
    exp_t e;
    e.id = id; e.data = data; e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 0);
    chk({tag, "_core_key"},  32'(core_key),  0);
    chk({tag, "_core_data"}, 32'(core_data), 0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    chk({tag, "_rsp_id"},    32'(rsp_id),    0);
    chk({tag, "_rsp_data"},  32'(rsp_data),  0);
    chk({tag, "_rsp_err"},   32'(rsp_err),   0);
    chk({tag, "_busy"},      32'(busy),      0);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 60) begin
      @(negedge clock);
      n++;
    end
    chk({name, "_idle_timeout"}, 32'(n < 60), 1);
  endtask

  task automatic wait_grant(input string name);
    int n = 0;
    while (req_ready == 4'b0 && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk({name, "_grant_timeout"}, 32'(n < 20), 1);
  endtask

  // Monitor: compare each handshaken response against the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 32'(rsp_id), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_id",   32'(rsp_id),   32'(e.id));
          chk("rsp_data", 32'(rsp_data), 32'(e.data));
          chk("rsp_err",  32'(rsp_err),  32'(e.err));
        end
      end
    end
  end

  initial begin
    int g_cyc [5];
    logic [1:0] rr_order [5];

    reset_n   = 1'b0;
    rsp_ready = 1'b0;
    req_valid = 4'b0;
    for (int i = 0; i < 4; i++) begin
      key_t[i] = 8'h00;
      dat_t[i] = 8'h00;
    end

    // Reset held with random inputs
    for (int c = 0; c < 3; c++) begin
      @(posedge clock); #1;
      req_valid = 4'($urandom);
      rsp_ready = 1'($urandom);
      for (int i = 0; i < 4; i++) begin
        key_t[i] = 8'($urandom);
        dat_t[i] = 8'($urandom);
      end
      @(negedge clock);
      chk_all_zero("reset");
    end

    // Fixed request table: expected core output = (key ^ data) + 8'h11
    key_t[0] = 8'h0F; dat_t[0] = 8'h02;   // -> 1E
    key_t[1] = 8'hA5; dat_t[1] = 8'h3C;   // -> AA
    key_t[2] = 8'h12; dat_t[2] = 8'h34;   // -> 37
    key_t[3] = 8'h30; dat_t[3] = 8'h03;   // -> 44

    // Release: requester 3 alone wins
    @(posedge clock); #1;
    req_valid = 4'b1000;
    rsp_ready = 1'b1;
    reset_n   = 1'b1;
    @(negedge clock);
    chk("post_reset_ready", 32'(req_ready), 32'h8);
    push_exp(2'd3, 8'h44, 1'b0);
    @(posedge clock); #1;
    req_valid = 4'b0;
    wait_idle("req3");

    // Single request from requester 0, latency check
    @(posedge clock); #1;
    req_valid = 4'b0001;
    @(negedge clock);
    chk("single_ready", 32'(req_ready), 32'h1);
    push_exp(2'd0, 8'h1E, 1'b0);
    @(posedge clock); #1;
    req_valid = 4'b0;
    chk("single_core_key",  32'(core_key),  32'h0F);
    chk("single_core_data", 32'(core_data), 32'h02);
    chk("single_busy",      32'(busy),      1);
    @(posedge clock); #1;
    chk("single_valid_e1",  32'(rsp_valid), 0);
    @(posedge clock); #1;
    chk("single_valid_e2",  32'(rsp_valid), 1);
    wait_idle("single");

    // Reset pulse so round-robin starts with requester 0
    @(posedge clock); #1;
    reset_n = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;

    // Round-robin with all requesters pending
    rr_order[0] = 2'd0; rr_order[1] = 2'd1; rr_order[2] = 2'd2;
    rr_order[3] = 2'd3; rr_order[4] = 2'd0;
    push_exp(2'd0, 8'h1E, 1'b0);
    push_exp(2'd1, 8'hAA, 1'b0);
    push_exp(2'd2, 8'h37, 1'b0);
    push_exp(2'd3, 8'h44, 1'b0);
    push_exp(2'd0, 8'h1E, 1'b0);
    req_valid = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      @(negedge clock);
      wait_grant("rr");
      g_cyc[g] = cyc;
      chk("rr_grant", 32'(req_ready), 32'(4'b0001 << rr_order[g]));
      if (g > 0) chk("rr_period", 32'(g_cyc[g] - g_cyc[g-1]), 4);
      @(posedge clock); #1;
    end
    req_valid = 4'b0;
    wait_idle("rr");

    // Backpressure: requester 1 wins, response held 5 cycles
    @(posedge clock); #1;
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    @(negedge clock);
    chk("bp_ready", 32'(req_ready), 32'h2);
    push_exp(2'd1, 8'hAA, 1'b0);
    @(posedge clock); #1;
    req_valid = 4'b1111;
    begin
      int n = 0;
      while (!rsp_valid && n < 10) begin
        @(negedge clock);
        n++;
      end
      chk("bp_valid_timeout", 32'(n < 10), 1);
    end
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clock);
      chk("bp_hold_valid", 32'(rsp_valid), 1);
      chk("bp_hold_id",    32'(rsp_id),    1);
      chk("bp_hold_data",  32'(rsp_data),  32'hAA);
      chk("bp_hold_ready", 32'(req_ready), 0);
    end
    @(posedge clock); #1;
    rsp_ready = 1'b1;
    @(posedge clock); #1;
    req_valid = 4'b0;
    chk("bp_done_valid", 32'(rsp_valid), 0);
    chk("bp_done_busy",  32'(busy),      0);
    wait_idle("bp");

    // Mid-operation reset during WAIT
    @(posedge clock); #1;
    req_valid = 4'b0001;
    @(negedge clock);
    wait_grant("midrst");
    @(posedge clock); #1;
    chk("midrst_busy", 32'(busy), 1);
    reset_n   = 1'b0;
    req_valid = 4'b0100;
    #1;
    chk_all_zero("midrst");
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b1;
    @(negedge clock);
    chk("midrst_req2_ready", 32'(req_ready), 32'h4);
    push_exp(2'd2, 8'h37, 1'b0);
    @(posedge clock); #1;
    req_valid = 4'b0;
    wait_idle("midrst");

    // Zero key from requester 1 (last grant was 2, so 1 wins after 3,0)
    key_t[1] = 8'h00; dat_t[1] = 8'h01;
    @(posedge clock); #1;
    req_valid = 4'b0010;
    @(negedge clock);
    chk("zkey_ready", 32'(req_ready), 32'h2);
`ifdef ENC_ARB_KEYCHK_EN
    push_exp(2'd1, 8'h00, 1'b1);
    @(posedge clock); #1;
    req_valid = 4'b0;
    chk("zkey_valid_e1",  32'(rsp_valid), 1);
    chk("zkey_core_key",  32'(core_key),  32'h12);
    chk("zkey_core_data", 32'(core_data), 32'h34);
`else
    push_exp(2'd1, 8'h12, 1'b0);
    @(posedge clock); #1;
    req_valid = 4'b0;
    chk("zkey_core_key",  32'(core_key),  32'h00);
    chk("zkey_core_data", 32'(core_data), 32'h01);
    chk("zkey_valid_e1",  32'(rsp_valid), 0);
`endif
    wait_idle("zkey");

    repeat (3) @(posedge clock);
    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/enc_arbiter.md
# enc_arbiter

Round-robin arbiter and sequencer that shares one `encryption` core among `NREQ` requesters. It accepts one {key, data} request at a time and drives the core's key and data inputs. It waits out the core latency, then returns the encrypted byte with the requester ID over a valid/ready response channel. It sits between the requesting agents and the single `encryption` instance.

## Interface
- `N`, 8, data/key width in bits (matches the encryption core)
- `NREQ`, 4, number of requesters (2..8)
- `LAT`, 1, core latency: clock edges from stable `core_key`/`core_data` to valid `core_e_data`
- `IDW`, derived `$clog2(NREQ)`, requester ID width

- `clock`  in  1  single clock; all state updates on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  NREQ  request pending, one bit per requester
- `req_ready`  out  NREQ  one-hot accept, combinational
- `req_key`  in  NREQ*N  packed keys; requester i at bits [i*N +: N]
- `req_data`  in  NREQ*N  packed plaintext; same packing as `req_key`
- `core_key`  out  N  registered key to the encryption core
- `core_data`  out  N  registered data to the encryption core
- `core_e_data`  in  N  encryption core output
- `rsp_valid`  out  1  response available
- `rsp_ready`  in  1  response consumer ready
- `rsp_id`  out  IDW  index of the requester that was served
- `rsp_data`  out  N  captured encrypted byte
- `rsp_err`  out  1  request rejected (see Configuration)
- `busy`  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, WAIT, RESP.
- **IDLE**
  - Winner = first asserted `req_valid` searched from `last_grant+1` upward, wrapping mod NREQ.
  - `req_ready[winner]`=1; all other `req_ready` bits are 0.
  - Zero `req_valid` means `req_ready`=0 and the FSM stays in IDLE.
- **Accept edge** (winner valid & ready)
  - `core_key`/`core_data` load the winner's key/data.
  - `rsp_id` loads the winner index and `last_grant` loads the winner.
  - Counter `cnt` loads `LAT`; next state is WAIT.
- **WAIT**
  - `req_ready`=0.
  - `cnt` decrements each cycle while nonzero.
  - On the edge where `cnt`==0, `rsp_data` captures `core_e_data` and the next state is RESP.
- **RESP**
  - `rsp_valid`=1; `rsp_id`, `rsp_data`, `rsp_err` are held stable until `rsp_ready`=1.
  - On the edge with `rsp_ready`=1, return to IDLE.
  - `rsp_ready` is ignored outside RESP.
- `core_key`/`core_data` hold their last value until the next accept.
- A requester may deassert `req_valid` without being accepted; no state is kept for it.
- `req_valid` changes during WAIT/RESP have no effect; arbitration occurs only in IDLE.
- Fairness: a requester that keeps `req_valid` high is served within NREQ grants.

## Timing
- **Reset values:**
  - `req_ready`=0, `core_key`=0, `core_data`=0.
  - `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0, `rsp_err`=0, `busy`=0.
  - State=IDLE, `cnt`=0, `last_grant`=NREQ-1, so requester 0 has first priority.
- Latency: accept at edge E0 → `rsp_valid` high after edge E0+LAT+1. With LAT=1, `rsp_valid` rises 2 edges after accept.
- Throughput with `rsp_ready` held high: one request per LAT+3 cycles.
- No accept can occur in the same cycle as a response handshake; the next accept is in the first IDLE cycle.
- `reset_n` asserted mid-operation: immediate async return to reset values. The in-flight request is dropped with no response.
- Deassertion of `reset_n` is synchronous to `clock` (externally synchronized).

## Configuration
- Macro: `ENC_ARB_KEYCHK_EN`.
- **Defined:** a winner whose key is all zeros is accepted normally (`req_ready` pulses) and bypasses the core.
  - `core_key`/`core_data` are not updated.
  - Next state is RESP directly, with `rsp_err`=1 and `rsp_data`=0.
  - Every non-zero-key response has `rsp_err`=0.
- **Undefined:** `rsp_err` is constant 0, and key 0 is processed like any other key.

## Test plan
- **Reset:** hold `reset_n`=0 with random inputs → all outputs 0. After release, `req_valid`=4'b1000 → `req_ready`=4'b1000.
- **Single request, LAT=1:** req0 key=8'h0F data=8'h02 → `core_key`=8'h0F, `core_data`=8'h02 after E0. `rsp_valid`=1 after E0+2 with `rsp_id`=0 and `rsp_data` equal to the core output.
- **Round-robin:** all four `req_valid` high continuously and `rsp_ready`=1 → grant order 0,1,2,3,0. Each response `rsp_id` matches its grant.
- **Backpressure:** `rsp_ready`=0 for 5 cycles in RESP → `rsp_valid`, `rsp_id`, `rsp_data` are stable and `req_ready`=0 throughout. Response completes on the first `rsp_ready`=1 edge.
- **Mid-op reset:** assert `reset_n`=0 during WAIT → all outputs 0 immediately and no response is produced. After release, pending req2 is granted first if req0 and req1 are idle.
- **Key check** (`ENC_ARB_KEYCHK_EN` defined): req1 key=8'h00 data=8'h01 → accepted, response one edge later with `rsp_err`=1, `rsp_data`=0, `rsp_id`=1. `core_key` keeps its prior value.
